// File: rtl/sram_rr_arbiter_pkg.sv
// Shared types and defaults for the round-robin SRAM arbiter.
package sram_arb_pkg;
  typedef enum logic [1:0] {IDLE, ISSUE, RDWAIT, RESP} arb_state_t;

  localparam int DEF_N_REQ      = 4;
  localparam int DEF_AW         = 8;
  localparam int DEF_DW         = 8;
  localparam int DEF_RD_LATENCY = 1;

  // Width of a requester index; never narrower than one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/sram_rr_arbiter_if.sv
// Client-side bus of the SRAM arbiter: per-requester request lanes plus shared return.
interface sram_rr_arbiter_if import sram_arb_pkg::*; #(
  parameter int N_REQ = DEF_N_REQ,
  parameter int AW    = DEF_AW,
  parameter int DW    = DEF_DW
) ();
  logic [N_REQ-1:0]         req;
  logic [N_REQ-1:0]         we;
  logic [N_REQ-1:0][AW-1:0] addr;
  logic [N_REQ-1:0][DW-1:0] wdata;
  logic [N_REQ-1:0]         gnt;
  logic [N_REQ-1:0]         rvalid;
  logic [DW-1:0]            rdata;
  logic                     busy;

  modport master (output req, we, addr, wdata, input gnt, rvalid, rdata, busy);
  modport slave  (input req, we, addr, wdata, output gnt, rvalid, rdata, busy);
endinterface

// File: rtl/sram_rr_arbiter_rr_pick.sv
// Combinational rotating-priority pick: first set req bit after 'last', wrapping.
module rr_pick #(
  parameter int N_REQ = 4,
  parameter int IW    = 2
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IW-1:0]    last,
  output logic [N_REQ-1:0] winner,
  output logic [IW-1:0]    idx,
  output logic             any
);
  logic [IW-1:0] c;

  always_comb begin
    winner = '0;
    idx    = '0;
    any    = 1'b0;
    c      = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      c = IW'((int'(last) + k) % N_REQ);
      if (!any && req[c]) begin
        any       = 1'b1;
        idx       = c;
        winner[c] = 1'b1;
      end
    end
  end
endmodule

// File: rtl/sram_rr_arbiter.sv
// Round-robin arbiter sharing one single-port SRAM; one access in flight at a time.
module sram_rr_arbiter import sram_arb_pkg::*; #(
  parameter int N_REQ      = DEF_N_REQ,
  parameter int AW         = DEF_AW,
  parameter int DW         = DEF_DW,
  parameter int RD_LATENCY = DEF_RD_LATENCY
) (
  input  logic               clk,
  input  logic               rst,
  sram_rr_arbiter_if.slave   bus,
  output logic [AW-1:0]      mem_addr,
  output logic [DW-1:0]      mem_din,
  output logic               mem_wen,
  input  logic [DW-1:0]      mem_dout
);
  localparam int IW = idx_w(N_REQ);

  arb_state_t       state, state_n;
  logic [IW-1:0]    last_r, pick_idx;
  logic [N_REQ-1:0] pick_oh, sel_r, gnt, rvalid;
  logic             pick_any, we_r;
  logic [AW-1:0]    addr_r;
  logic [DW-1:0]    wdata_r, rdata_r;
  logic [1:0]       cnt_r, cnt_n;

  rr_pick #(.N_REQ(N_REQ), .IW(IW)) u_pick (
    .req    (bus.req),
    .last   (last_r),
    .winner (pick_oh),
    .idx    (pick_idx),
    .any    (pick_any)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      last_r  <= IW'(N_REQ - 1);
      sel_r   <= '0;
      we_r    <= 1'b0;
      addr_r  <= '0;
      wdata_r <= '0;
      rdata_r <= '0;
      cnt_r   <= '0;
    end else begin
      state <= state_n;
      cnt_r <= cnt_n;
      if (state == IDLE && pick_any) begin
        last_r  <= pick_idx;
        sel_r   <= pick_oh;
        we_r    <= bus.we[pick_idx];
        addr_r  <= bus.addr[pick_idx];
        wdata_r <= bus.wdata[pick_idx];
      end
      if (state == RESP) rdata_r <= mem_dout;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt_r;
    gnt     = '0;
    rvalid  = '0;
    case (state)
      IDLE:   if (pick_any) state_n = ISSUE;
      ISSUE: begin
        gnt = sel_r;
        if (we_r) state_n = IDLE;
        else begin
          cnt_n   = 2'(RD_LATENCY - 1);
          state_n = (RD_LATENCY == 1) ? RESP : RDWAIT;
        end
      end
      RDWAIT: begin
        cnt_n = cnt_r - 2'd1;
        if (cnt_r <= 2'd1) state_n = RESP;
      end
      RESP: begin
        rvalid  = sel_r;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // Capture registers double as the SRAM pins, so they hold between accesses.
  assign mem_addr   = addr_r;
  assign mem_din    = wdata_r;
  assign mem_wen    = (state == ISSUE) && we_r;
  assign bus.gnt    = gnt;
  assign bus.rvalid = rvalid;
  assign bus.rdata  = (state == RESP) ? mem_dout : rdata_r;
  assign bus.busy   = (state != IDLE);
endmodule
